// File: rtl/mdu_issue_ctrl_if.sv
// Start/busy/HI-LO handshake between the E-stage issue controller (master) and the MDU (slave).
interface mdu_issue_ctrl_if;
    logic       start;
    logic [2:0] mdu_op;
    logic       hi_write;
    logic       lo_write;
    logic       mdu_busy;

    modport master (output start, output mdu_op, output hi_write, output lo_write, input mdu_busy);
    modport slave  (input start, input mdu_op, input hi_write, input lo_write, output mdu_busy);
endinterface

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issue controller: decode, busy-window tracking, D-stage stall and stall counter.
// Optional busy watchdog enabled by defining MDU_WATCHDOG_EN.
module mdu_issue_ctrl #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_BUSY = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr_d,
    input  logic [31:0]          instr_e,
    input  logic                 valid_e,
    mdu_issue_ctrl_if.master     mdu,
    output logic [1:0]           mf_sel,
    output logic                 stall_d,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic                 mdu_timeout
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             wd_hit;
    logic             resync_block;

    logic e_special, d_special;
    logic e_muldiv, e_mfhi, e_mflo, e_mthi, e_mtlo;
    logic d_mdu;

    logic unused_bits;
    assign unused_bits = ^{instr_d[25:6], instr_e[25:6]};

    assign e_special = (instr_e[31:26] == 6'b000000);
    assign d_special = (instr_d[31:26] == 6'b000000);

    always_comb begin
        e_muldiv = 1'b0;
        e_mfhi   = 1'b0;
        e_mflo   = 1'b0;
        e_mthi   = 1'b0;
        e_mtlo   = 1'b0;
        if (e_special) begin
            unique case (instr_e[5:0])
                6'h18, 6'h19, 6'h1A, 6'h1B: e_muldiv = 1'b1;
                6'h10:                      e_mfhi   = 1'b1;
                6'h12:                      e_mflo   = 1'b1;
                6'h11:                      e_mthi   = 1'b1;
                6'h13:                      e_mtlo   = 1'b1;
                default:                    ;
            endcase
        end
    end

    always_comb begin
        d_mdu = 1'b0;
        if (d_special) begin
            unique case (instr_d[5:0])
                6'h18, 6'h19, 6'h1A, 6'h1B,
                6'h10, 6'h11, 6'h12, 6'h13: d_mdu = 1'b1;
                default:                    ;
            endcase
        end
    end

`ifdef MDU_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(MAX_BUSY + 1);

    logic [WdW-1:0] wd_q;
    logic           timeout_q;

    assign wd_hit       = (state_q == StBusy) && mdu.mdu_busy && (wd_q == WdW'(MAX_BUSY - 1));
    // After a timeout the MDU is presumed stuck, so a lingering busy must not re-arm the stall.
    assign resync_block = timeout_q;
    assign mdu_timeout  = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == StIdle && state_d == StBusy) begin
                wd_q <= '0;
            end else if (state_q == StBusy && mdu.mdu_busy) begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_max_busy;
    assign unused_max_busy = ^MAX_BUSY;
    assign wd_hit          = 1'b0;
    assign resync_block    = 1'b0;
    assign mdu_timeout     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mdu.start || (mdu.mdu_busy && !resync_block)) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!mdu.mdu_busy || wd_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; all strobes and the stall are forced low during the reset cycle
    always_comb begin
        mdu.start    = 1'b0;
        mdu.mdu_op   = 3'b000;
        mdu.hi_write = 1'b0;
        mdu.lo_write = 1'b0;
        mf_sel       = 2'b00;
        stall_d      = 1'b0;
        if (!reset) begin
            mdu.start    = valid_e && e_muldiv && (state_q == StIdle);
            mdu.hi_write = valid_e && e_mthi && (state_q == StIdle);
            mdu.lo_write = valid_e && e_mtlo && (state_q == StIdle);
            if (mdu.start) begin
                // funct 18/19/1A/1B -> 001/000/011/010
                mdu.mdu_op = {1'b0, instr_e[1], ~instr_e[0]};
            end
            if (valid_e && e_mfhi) begin
                mf_sel = 2'b01;
            end else if (valid_e && e_mflo) begin
                mf_sel = 2'b10;
            end
            stall_d = d_mdu && ((valid_e && e_muldiv) ||
                                ((state_q == StBusy) && mdu.mdu_busy));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (stall_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: vector table, directed sequences, random vs. model.
module tb_mdu_issue_ctrl;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_BUSY = 16;

    logic             clk;
    logic             reset;
    logic [31:0]      instr_d;
    logic [31:0]      instr_e;
    logic             valid_e;
    logic [1:0]       mf_sel;
    logic             stall_d;
    logic [CNT_W-1:0] stall_cnt;
    logic             mdu_timeout;

    int errors = 0;
    int checks = 0;

    mdu_issue_ctrl_if mdu_if ();

    mdu_issue_ctrl #(
        .CNT_W    (CNT_W),
        .MAX_BUSY (MAX_BUSY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_d     (instr_d),
        .instr_e     (instr_e),
        .valid_e     (valid_e),
        .mdu         (mdu_if.master),
        .mf_sel      (mf_sel),
        .stall_d     (stall_d),
        .stall_cnt   (stall_cnt),
        .mdu_timeout (mdu_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        logic        s;
        logic [2:0]  op;
        logic        hw;
        logic        lw;
        logic [1:0]  mf;
        logic        st;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] sp(input logic [5:0] f);
        return {6'b000000, 20'h0A5C3, f};
    endfunction

    function automatic logic is_sp(input logic [31:0] i);
        return i[31:26] == 6'd0;
    endfunction
    function automatic logic is_muldiv(input logic [31:0] i);
        return is_sp(i) && (i[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction
    function automatic logic is_mdu(input logic [31:0] i);
        return is_muldiv(i) || (is_sp(i) && (i[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13}));
    endfunction
    function automatic logic is_f(input logic [31:0] i, input logic [5:0] f);
        return is_sp(i) && (i[5:0] == f);
    endfunction
    function automatic logic [2:0] op_of(input logic [5:0] f);
        case (f)
            6'h18:   return 3'b001;
            6'h19:   return 3'b000;
            6'h1A:   return 3'b011;
            6'h1B:   return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] mdu_f[8];
        int         r;
        mdu_f = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13};
        r = $urandom_range(0, 11);
        if (r < 8)   return {6'd0, 20'($urandom), mdu_f[r]};
        if (r == 8)  return {6'd0, 20'($urandom), 6'h21};
        if (r == 9)  return {6'd0, 20'($urandom), 6'h2A};
        if (r == 10) return {6'd0, 20'($urandom), 6'h00};
        return {6'h23, 20'($urandom), mdu_f[$urandom_range(0, 7)]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic es, input logic [2:0] eo,
                            input logic eh, input logic el, input logic [1:0] em,
                            input logic est);
        chk({tag, ".start"},    32'(mdu_if.start),    32'(es));
        chk({tag, ".mdu_op"},   32'(mdu_if.mdu_op),   32'(eo));
        chk({tag, ".hi_write"}, 32'(mdu_if.hi_write), 32'(eh));
        chk({tag, ".lo_write"}, 32'(mdu_if.lo_write), 32'(el));
        chk({tag, ".mf_sel"},   32'(mf_sel),          32'(em));
        chk({tag, ".stall_d"},  32'(stall_d),         32'(est));
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_e = 1'b0;
        mdu_if.mdu_busy = 1'b0;
        nxt();
        reset = 1'b0;
    endtask

    logic [31:0] rst_e[3];
    bit          win, to, s_exp;
    int          cnt, wdc;
    logic [2:0]  op_exp;

    initial begin
        reset = 1'b1;
        instr_d = '0;
        instr_e = '0;
        valid_e = 1'b0;
        mdu_if.mdu_busy = 1'b0;
        nxt();

        // Reset cycle masks every output whatever the inputs
        rst_e = '{sp(6'h18), sp(6'h10), sp(6'h11)};
        for (int i = 0; i < 3; i++) begin
            reset = 1'b1;
            instr_d = sp(6'h10);
            instr_e = rst_e[i];
            valid_e = 1'b1;
            mdu_if.mdu_busy = 1'b1;
            @(negedge clk);
            chk_outs("reset_cycle", 0, 0, 0, 0, 0, 0);
            chk("reset.stall_cnt", 32'(stall_cnt), 0);
            chk("reset.timeout", 32'(mdu_timeout), 0);
            nxt();
        end

        vecs[0]  = '{sp(6'h21), sp(6'h18), 1, 1, 3'b001, 0, 0, 2'd0, 0};
        vecs[1]  = '{sp(6'h12), sp(6'h18), 1, 1, 3'b001, 0, 0, 2'd0, 1};
        vecs[2]  = '{sp(6'h11), sp(6'h19), 1, 1, 3'b000, 0, 0, 2'd0, 1};
        vecs[3]  = '{sp(6'h10), sp(6'h1A), 1, 1, 3'b011, 0, 0, 2'd0, 1};
        vecs[4]  = '{sp(6'h21), sp(6'h1B), 1, 1, 3'b010, 0, 0, 2'd0, 0};
        vecs[5]  = '{sp(6'h18), sp(6'h18), 0, 0, 3'b000, 0, 0, 2'd0, 0};
        vecs[6]  = '{sp(6'h12), sp(6'h11), 1, 0, 3'b000, 1, 0, 2'd0, 0};
        vecs[7]  = '{sp(6'h21), sp(6'h13), 1, 0, 3'b000, 0, 1, 2'd0, 0};
        vecs[8]  = '{sp(6'h21), sp(6'h11), 0, 0, 3'b000, 0, 0, 2'd0, 0};
        vecs[9]  = '{sp(6'h21), sp(6'h10), 1, 0, 3'b000, 0, 0, 2'd1, 0};
        vecs[10] = '{sp(6'h21), sp(6'h12), 1, 0, 3'b000, 0, 0, 2'd2, 0};
        vecs[11] = '{sp(6'h21), sp(6'h12), 0, 0, 3'b000, 0, 0, 2'd0, 0};
        vecs[12] = '{sp(6'h13), {6'h23, 20'h0, 6'h18}, 1, 0, 3'b000, 0, 0, 2'd0, 0};
        vecs[13] = '{{6'h0F, 20'h0, 6'h10}, sp(6'h18), 1, 1, 3'b001, 0, 0, 2'd0, 0};

        for (int i = 0; i < 14; i++) begin
            do_reset();
            instr_d = vecs[i].d;
            instr_e = vecs[i].e;
            valid_e = vecs[i].v;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].s, vecs[i].op, vecs[i].hw, vecs[i].lw,
                     vecs[i].mf, vecs[i].st);
            nxt();
        end

        // mult with mflo behind it, MDU busy for 5 cycles
        do_reset();
        instr_d = sp(6'h12);
        instr_e = sp(6'h18);
        valid_e = 1'b1;
        @(negedge clk);
        chk_outs("mult_start", 1, 3'b001, 0, 0, 0, 1);
        nxt();
        valid_e = 1'b0;
        mdu_if.mdu_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_outs($sformatf("mult_busy%0d", i), 0, 0, 0, 0, 0, 1);
            nxt();
        end
        mdu_if.mdu_busy = 1'b0;
        @(negedge clk);
        chk("mult_release.stall_d", 32'(stall_d), 0);
        chk("mult_release.stall_cnt", 32'(stall_cnt), 6);
        nxt();

        // divu with an independent addu in D never stalls
        do_reset();
        instr_d = sp(6'h21);
        instr_e = sp(6'h1B);
        valid_e = 1'b1;
        @(negedge clk);
        chk_outs("divu_start", 1, 3'b010, 0, 0, 0, 0);
        nxt();
        valid_e = 1'b0;
        mdu_if.mdu_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("divu_busy%0d.stall_d", i), 32'(stall_d), 0);
            nxt();
        end
        mdu_if.mdu_busy = 1'b0;
        @(negedge clk);
        chk("divu_done.stall_cnt", 32'(stall_cnt), 0);
        nxt();

        // Resync into BUSY, then MULDIV/MT in E are dropped; release cycle needs no stall
        do_reset();
        instr_d = sp(6'h21);
        mdu_if.mdu_busy = 1'b1;
        nxt();
        instr_e = sp(6'h18);
        valid_e = 1'b1;
        @(negedge clk);
        chk_outs("busy_drop_mult", 0, 0, 0, 0, 0, 0);
        nxt();
        instr_e = sp(6'h11);
        @(negedge clk);
        chk_outs("busy_drop_mthi", 0, 0, 0, 0, 0, 0);
        nxt();
        instr_e = sp(6'h13);
        @(negedge clk);
        chk_outs("busy_drop_mtlo", 0, 0, 0, 0, 0, 0);
        nxt();
        instr_d = sp(6'h10);
        valid_e = 1'b0;
        @(negedge clk);
        chk("busy_mfhi.stall_d", 32'(stall_d), 1);
        nxt();
        mdu_if.mdu_busy = 1'b0;
        @(negedge clk);
        chk("busy_fall.stall_d", 32'(stall_d), 0);
        nxt();

        // Reset in the middle of an operation
        do_reset();
        instr_d = sp(6'h10);
        instr_e = sp(6'h18);
        valid_e = 1'b1;
        nxt();
        valid_e = 1'b0;
        mdu_if.mdu_busy = 1'b1;
        nxt();
        nxt();
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_cycle.stall_d", 32'(stall_d), 0);
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset.stall_d", 32'(stall_d), 0);
        chk("after_reset.stall_cnt", 32'(stall_cnt), 0);
        nxt();

        // Long busy: watchdog behaviour, and stall_cnt saturation at CNT_W=4
        do_reset();
        instr_d = sp(6'h12);
        instr_e = sp(6'h18);
        valid_e = 1'b1;
        nxt();
        valid_e = 1'b0;
        mdu_if.mdu_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
`ifdef MDU_WATCHDOG_EN
            chk($sformatf("long%0d.stall_d", i), 32'(stall_d), (i < 16) ? 1 : 0);
            chk($sformatf("long%0d.timeout", i), 32'(mdu_timeout), (i < 16) ? 0 : 1);
`else
            chk($sformatf("long%0d.stall_d", i), 32'(stall_d), 1);
            chk($sformatf("long%0d.timeout", i), 32'(mdu_timeout), 0);
`endif
            nxt();
        end
        mdu_if.mdu_busy = 1'b0;
        @(negedge clk);
        chk("long.stall_cnt_sat", 32'(stall_cnt), 15);
        nxt();

        // Random traffic against a rule-level model
        do_reset();
        win = 0; to = 0; cnt = 0; wdc = 0;
        for (int c = 0; c < 600; c++) begin
            reset   = ($urandom_range(0, 39) == 0);
            instr_d = rand_instr();
            instr_e = rand_instr();
            valid_e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) mdu_if.mdu_busy = ~mdu_if.mdu_busy;

            s_exp  = !reset && valid_e && is_muldiv(instr_e) && !win;
            op_exp = s_exp ? op_of(instr_e[5:0]) : 3'b000;
            @(negedge clk);
            if (reset) begin
                chk_outs("rand_rst", 0, 0, 0, 0, 0, 0);
            end else begin
                chk_outs("rand", s_exp, op_exp,
                         valid_e && is_f(instr_e, 6'h11) && !win,
                         valid_e && is_f(instr_e, 6'h13) && !win,
                         (valid_e && is_f(instr_e, 6'h10)) ? 2'd1 :
                         (valid_e && is_f(instr_e, 6'h12)) ? 2'd2 : 2'd0,
                         is_mdu(instr_d) &&
                         ((valid_e && is_muldiv(instr_e)) || (win && mdu_if.mdu_busy)));
            end
            chk("rand.stall_cnt", 32'(stall_cnt), 32'(cnt));
            chk("rand.timeout", 32'(mdu_timeout), 32'(to));

            if (reset) begin
                win = 0; to = 0; cnt = 0; wdc = 0;
            end else begin
                if (stall_d === 1'b1 && cnt < (1 << CNT_W) - 1) cnt++;
                if (!win) begin
                    if (s_exp || (mdu_if.mdu_busy && !to)) begin
                        win = 1;
                        wdc = 0;
                    end
                end else if (!mdu_if.mdu_busy) begin
                    win = 0;
                end else begin
`ifdef MDU_WATCHDOG_EN
                    wdc++;
                    if (wdc == MAX_BUSY) begin
                        to  = 1;
                        win = 0;
                    end
`endif
                end
            end
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Initiator side of the multiply/divide unit (MDU) start/busy/HI-LO protocol.
- Sits in the E stage. Decodes the D- and E-stage instructions and drives the MDU's start, op, HI-write and LO-write inputs.
- Tracks the MDU's busy window with its own state machine and produces the D-stage stall for every MDU-class instruction.
- Also selects HI/LO for the E-stage result mux and keeps a saturating MDU-stall performance counter.

Parameters:
- CNT_W, 16, width of the stall-cycle performance counter.
- MAX_BUSY, 16, watchdog limit in cycles (used only with MDU_WATCHDOG_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- instr_d  in  32  D-stage instruction word.
- instr_e  in  32  E-stage instruction word.
- valid_e  in  1  E-stage instruction is live (0 on bubble or flush).
- mdu_busy  in  1  busy output of the MDU.
- start  out  1  MDU start pulse.
- mdu_op  out  3  MDU operation: 000 multu, 001 mult, 010 divu, 011 div.
- hi_write  out  1  mthi write strobe to the MDU.
- lo_write  out  1  mtlo write strobe to the MDU.
- mf_sel  out  2  E result select: 00 ALU, 01 HI, 10 LO.
- stall_d  out  1  freeze F/D and insert a bubble into E.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_d=1.
- mdu_timeout  out  1  sticky watchdog flag (tied 0 without MDU_WATCHDOG_EN).

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Decode: SPECIAL is opcode 000000. Funct codes:
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu (class MULDIV).
  - 0x10 mfhi, 0x12 mflo (class MF).
  - 0x11 mthi, 0x13 mtlo (class MT).
  - MDU-class = MULDIV | MF | MT. Any other encoding is class none.
- State machine (2 states, registered):
  - IDLE -> BUSY when start=1, or when mdu_busy=1 while IDLE (resync).
  - BUSY -> IDLE when mdu_busy=0.
- E-stage outputs (combinational from instr_e, valid_e and state):
  - start = valid_e & E is MULDIV & state==IDLE.
  - mdu_op follows the funct code; it is 000 when start=0.
  - hi_write = valid_e & E is mthi & state==IDLE. lo_write is the same for mtlo.
  - mf_sel = 01 for a valid mfhi and 10 for a valid mflo, else 00.
- Stall:
  - stall_d = D is MDU-class & ((valid_e & E is MULDIV) | (state==BUSY & mdu_busy)).
  - The first term covers the start cycle, because the MDU's busy only rises the cycle after start.
  - In the cycle where mdu_busy has fallen while state is still BUSY, HI/LO are already final. No stall is needed that cycle.
  - Non-MDU instructions are never stalled; they proceed while the MDU works.
- Simultaneous events:
  - A MULDIV in E with state BUSY cannot occur, because the stall prevents it. If it does occur, start is held 0 and the instruction is dropped.
  - An MT in E with state BUSY is dropped in the same way: no write strobe.
- stall_cnt increments every cycle stall_d=1 and saturates at all-ones.
- Reset (including mid-operation): state=IDLE, stall_cnt=0, mdu_timeout=0. start, hi_write, lo_write, mf_sel and stall_d are all 0 for the reset cycle, regardless of inputs.
- Latency: start and the strobes are combinational, with zero cycles from E-stage entry. stall_d releases in the first cycle mdu_busy=0.

Optional Feature:
- MDU_WATCHDOG_EN defined:
  - A counter runs while state==BUSY & mdu_busy.
  - When the counter reaches MAX_BUSY, mdu_timeout is set (sticky until reset) and state is forced to IDLE, which releases the stall.
  - The counter clears on entering BUSY.
- MDU_WATCHDOG_EN undefined: no watchdog counter, mdu_timeout tied 0, and BUSY is exited only on mdu_busy=0.

Test Plan:
- mult (funct 0x18) in E, valid_e=1, state IDLE -> start=1 and mdu_op=001 for exactly 1 cycle; state=BUSY next cycle.
- mult in E with mflo in D; mdu_busy high for 5 cycles -> stall_d=1 for 6 cycles (start cycle plus 5), 0 on the first cycle busy=0, and stall_cnt=6.
- divu in E with addu in D, busy for 10 cycles -> stall_d=0 throughout; mdu_op=010.
- mthi (funct 0x11) in E, state IDLE -> hi_write=1 and lo_write=0. Same with valid_e=0 -> both strobes 0.
- reset asserted during BUSY with mfhi in D -> next cycle state=IDLE, stall_d=0, stall_cnt=0.
- With MDU_WATCHDOG_EN and MAX_BUSY=16, mdu_busy held high for 40 cycles -> mdu_timeout=1 after 16 busy cycles and stall_d=0 thereafter. Without the macro -> stall_d=1 for all 40 cycles and mdu_timeout=0.
